// File: rtl/screen_memory.sv
// CHIP-8 framebuffer: 64x32 monochrome pixels held as 256 bytes.
// Serves bridge reads and gives the cpu XOR-draw and clear operations,
// all through one single-port synchronous RAM, one access per cycle.
module screen_memory #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scr_read,
   input  logic [ADDR_WIDTH-1:0] scr_read_idx,
   output logic [7:0]            scr_read_byte,
   output logic                  scr_read_ack,
   input  logic                  draw_req,
   input  logic [ADDR_WIDTH-1:0] draw_idx,
   input  logic [7:0]            draw_byte,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  done,
   output logic                  draw_collision
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, RD, XR, CLR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic [7:0]            byte_q, byte_d;
   logic [7:0]            scr_read_byte_q, scr_read_byte_d;
   logic                  scr_read_ack_q, scr_read_ack_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  draw_collision_q, draw_collision_d;

   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic [7:0]            ram_wdata;
   logic [7:0]            ram_rdata_q;

   // Next-state logic and the single RAM port's address/write selection
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      clr_cnt_d        = clr_cnt_q;
      byte_d           = byte_q;
      scr_read_byte_d  = scr_read_byte_q;
      scr_read_ack_d   = 1'b0;
      done_d           = 1'b0;
      draw_collision_d = draw_collision_q;
      ram_addr         = idx_q;
      ram_we           = 1'b0;
      ram_wdata        = '0;
      unique case (state_q)
         IDLE: begin
            // clear wins over draw; a read waits behind both and is not
            // re-accepted while its own ack is still on the wire
            if (clear_req) begin
               state_d = CLR;
            end else if (draw_req) begin
               idx_d    = draw_idx;
               byte_d   = draw_byte;
               ram_addr = draw_idx;
               state_d  = XR;
            end else if (scr_read && !scr_read_ack_q) begin
               idx_d    = scr_read_idx;
               ram_addr = scr_read_idx;
               state_d  = RD;
            end
         end
         RD: begin
            scr_read_byte_d = ram_rdata_q;
            scr_read_ack_d  = 1'b1;
            state_d         = IDLE;
         end
         XR: begin
            ram_addr         = idx_q;
            ram_we           = 1'b1;
            ram_wdata        = ram_rdata_q ^ byte_q;
            draw_collision_d = |(ram_rdata_q & byte_q);
            done_d           = 1'b1;
            state_d          = IDLE;
         end
         CLR: begin
            ram_addr  = clr_cnt_q;
            ram_we    = 1'b1;
            ram_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Control and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         idx_q            <= '0;
         clr_cnt_q        <= '0;
         byte_q           <= '0;
         scr_read_byte_q  <= '0;
         scr_read_ack_q   <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         draw_collision_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         clr_cnt_q        <= clr_cnt_d;
         byte_q           <= byte_d;
         scr_read_byte_q  <= scr_read_byte_d;
         scr_read_ack_q   <= scr_read_ack_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         draw_collision_q <= draw_collision_d;
      end
   end

   // Single-port RAM with registered read; contents are not reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata_q <= mem[ram_addr];
   end

   // Draw and clear requests must not arrive while an operation is running
   assert property (@(posedge clk) disable iff (reset)
                    !(busy_q && (draw_req || clear_req)));

   assign scr_read_byte  = scr_read_byte_q;
   assign scr_read_ack   = scr_read_ack_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign draw_collision = draw_collision_q;

endmodule

// File: tb/tb_screen_memory.sv
// Bench for screen_memory: transaction-level model of the framebuffer with
// a per-cycle expectation timeline, checked every cycle on the falling edge.
module tb_screen_memory;

   localparam int MAXC = 8000;

   logic       clk = 1'b0;
   logic       reset;
   logic       scr_read;
   logic [7:0] scr_read_idx;
   logic [7:0] scr_read_byte;
   logic       scr_read_ack;
   logic       draw_req;
   logic [7:0] draw_idx;
   logic [7:0] draw_byte;
   logic       clear_req;
   logic       busy;
   logic       done;
   logic       draw_collision;

   screen_memory #(.ADDR_WIDTH(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .scr_read       (scr_read),
      .scr_read_idx   (scr_read_idx),
      .scr_read_byte  (scr_read_byte),
      .scr_read_ack   (scr_read_ack),
      .draw_req       (draw_req),
      .draw_idx       (draw_idx),
      .draw_byte      (draw_byte),
      .clear_req      (clear_req),
      .busy           (busy),
      .done           (done),
      .draw_collision (draw_collision)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expectation timeline indexed by cycle number
   bit         exp_busy [MAXC];
   bit         exp_done [MAXC];
   bit         exp_ack  [MAXC];
   logic [7:0] exp_rb   [MAXC];
   bit         exp_cev  [MAXC];
   bit         exp_cv   [MAXC];

   logic [7:0] mem_model [256];
   logic [7:0] cur_rbyte = 8'h00;
   logic       cur_coll  = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   bit         chk_en = 1'b0;
   int         ack_cycs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // per-cycle compare against the timeline
   always @(negedge clk) begin
      if (chk_en && !reset && cyc < MAXC) begin
         if (exp_ack[cyc]) cur_rbyte = exp_rb[cyc];
         if (exp_cev[cyc]) cur_coll = exp_cv[cyc];
         chk("busy", 32'(busy), 32'(exp_busy[cyc]));
         chk("done", 32'(done), 32'(exp_done[cyc]));
         chk("ack", 32'(scr_read_ack), 32'(exp_ack[cyc]));
         chk("rbyte", 32'(scr_read_byte), 32'(cur_rbyte));
         chk("coll", 32'(draw_collision), 32'(cur_coll));
         if (scr_read_ack) ack_cycs.push_back(cyc);
      end
   end

   task automatic op_draw(input logic [7:0] idx, input logic [7:0] b);
      int a = cyc;
      draw_req = 1'b1; draw_idx = idx; draw_byte = b;
      exp_busy[a+1] = 1'b1;
      exp_done[a+2] = 1'b1;
      exp_cev[a+2]  = 1'b1;
      exp_cv[a+2]   = |(mem_model[idx] & b);
      mem_model[idx] = mem_model[idx] ^ b;
      tick(); draw_req = 1'b0;
      tick();
   endtask

   task automatic op_read(input logic [7:0] idx);
      int a = cyc;
      scr_read = 1'b1; scr_read_idx = idx;
      exp_busy[a+1] = 1'b1;
      exp_ack[a+2]  = 1'b1;
      exp_rb[a+2]   = mem_model[idx];
      tick(); tick(); tick();
      scr_read = 1'b0;
   endtask

   task automatic op_draw_read(input logic [7:0] idx, input logic [7:0] b);
      int a = cyc;
      draw_req = 1'b1; draw_idx = idx; draw_byte = b;
      scr_read = 1'b1; scr_read_idx = idx;
      exp_busy[a+1] = 1'b1;
      exp_done[a+2] = 1'b1;
      exp_cev[a+2]  = 1'b1;
      exp_cv[a+2]   = |(mem_model[idx] & b);
      mem_model[idx] = mem_model[idx] ^ b;
      exp_busy[a+3] = 1'b1;
      exp_ack[a+4]  = 1'b1;
      exp_rb[a+4]   = mem_model[idx];
      tick(); draw_req = 1'b0;
      repeat (4) tick();
      scr_read = 1'b0;
   endtask

   task automatic do_reset();
      int k = cyc;
      #6;
      reset = 1'b1;
      scr_read = 1'b0; draw_req = 1'b0; clear_req = 1'b0;
      cur_rbyte = 8'h00;
      cur_coll  = 1'b0;
      for (int j = k + 1; j < k + 300 && j < MAXC; j++) begin
         exp_busy[j] = 1'b0; exp_done[j] = 1'b0;
         exp_ack[j]  = 1'b0; exp_cev[j]  = 1'b0;
      end
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ack", 32'(scr_read_ack), 32'd0);
      chk("rst_rbyte", 32'(scr_read_byte), 32'd0);
      chk("rst_coll", 32'(draw_collision), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      tick();
   endtask

   task automatic op_clear(input bit with_draw, input int abort_at);
      int a = cyc;
      clear_req = 1'b1;
      if (with_draw) begin
         draw_req  = 1'b1;
         draw_idx  = 8'($urandom);
         draw_byte = 8'($urandom);
      end
      for (int j = 1; j <= 256; j++) exp_busy[a+j] = 1'b1;
      exp_done[a+257] = 1'b1;
      for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
      tick(); clear_req = 1'b0; draw_req = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at - 1) tick();
         do_reset();
      end else begin
         repeat (256) tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      scr_read = 1'b0; scr_read_idx = 8'h00;
      draw_req = 1'b0; draw_idx = 8'h00; draw_byte = 8'h00;
      clear_req = 1'b0;
      repeat (3) tick();
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_done", 32'(done), 32'd0);
      chk("init_ack", 32'(scr_read_ack), 32'd0);
      chk("init_rbyte", 32'(scr_read_byte), 32'd0);
      chk("init_coll", 32'(draw_collision), 32'd0);
      reset = 1'b0;
      chk_en = 1'b1;
      tick();

      // clear then read both ends of the framebuffer
      op_clear(1'b0, 0);
      chk("clr_done_lit", 32'(done), 32'd1);
      op_read(8'h00);
      chk("rd00_lit", 32'(scr_read_byte), 32'h00);
      op_read(8'hFF);
      chk("rdFF_lit", 32'(scr_read_byte), 32'h00);

      // draw then read, with and without collision
      op_draw(8'd5, 8'hF0);
      chk("draw1_coll_lit", 32'(draw_collision), 32'd0);
      op_read(8'd5);
      chk("rd5a_lit", 32'(scr_read_byte), 32'hF0);
      op_draw(8'd5, 8'h30);
      chk("draw2_coll_lit", 32'(draw_collision), 32'd1);
      op_read(8'd5);
      chk("rd5b_lit", 32'(scr_read_byte), 32'hC0);

      // asynchronous reset while idle with non-zero outputs; RAM survives
      do_reset();
      op_read(8'd5);
      chk("rd5_after_rst_lit", 32'(scr_read_byte), 32'hC0);

      // simultaneous draw and read of the same byte
      op_draw_read(8'd7, 8'hAA);
      chk("draw_read_lit", 32'(scr_read_byte), 32'hAA);

      // back-to-back reads: acks three cycles apart
      ack_cycs.delete();
      op_read(8'd1);
      op_read(8'd2);
      chk("b2b_acks", 32'(ack_cycs.size()), 32'd2);
      if (ack_cycs.size() == 2)
         chk("b2b_gap", 32'(ack_cycs[1] - ack_cycs[0]), 32'd3);

      // reset in the middle of a clear, then a full clear
      op_clear(1'b0, 100);
      op_clear(1'b1, 0);
      op_read(8'h00);
      op_read(8'hFF);
      for (int i = 0; i < 12; i++) op_read(8'($urandom));

      // randomized mix
      for (int n = 0; n < 200 && cyc < MAXC - 700; n++) begin
         int r = $urandom_range(0, 99);
         if (r < 35)      op_draw(8'($urandom), 8'($urandom));
         else if (r < 70) op_read(8'($urandom));
         else if (r < 80) op_draw_read(8'($urandom), 8'($urandom));
         else if (r < 82) op_clear(1'($urandom), 0);
         else             repeat ($urandom_range(1, 3)) tick();
      end

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
